// File: rtl/id_issue_ctrl.sv
// ============================================================================
// Module      : id_issue_ctrl
// Description : Fetch buffer, register scoreboard and serialising issue FSM
//               sitting in front of the ID decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_inst,
    output logic             if_ready,
    output logic [31:0]      dec_inst,
    input  logic [4:0]       dec_rd,
    input  logic [4:0]       dec_rj,
    input  logic [4:0]       dec_rk,
    input  logic             dec_long,
    input  logic             dec_serial,
    output logic             issue_valid,
    output logic [31:0]      issue_pc,
    output logic [31:0]      issue_inst,
    input  logic             issue_ready,
    input  logic             pipe_empty,
    input  logic             serial_done,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [31:0]      busy;
    logic [31:0]      busy_nxt;

    logic head_valid;
    logic push;
    logic pop;
    logic raw;
    logic waw;
    logic hazard;
    logic drained;

    assign head_valid = (count != '0);
    assign if_ready   = (count < FULL_CNT);
    assign push       = if_valid & if_ready & ~flush;
    assign pop        = issue_valid & issue_ready;

    assign dec_inst   = head_valid ? inst_mem[rd_ptr] : 32'd0;
    assign issue_inst = head_valid ? inst_mem[rd_ptr] : 32'd0;
    assign issue_pc   = head_valid ? pc_mem[rd_ptr]   : 32'd0;

    assign raw     = ((dec_rj != 5'd0) & busy[dec_rj]) | ((dec_rk != 5'd0) & busy[dec_rk]);
    assign waw     = (dec_rd != 5'd0) & busy[dec_rd];
    assign hazard  = raw | waw;
    assign drained = (busy == 32'd0) & pipe_empty;

    always_comb begin
        issue_valid = 1'b0;
        if (!flush && head_valid) begin
            case (state)
                RUN:     issue_valid = dec_serial ? drained : ~hazard;
                DRAIN:   issue_valid = drained;
                default: issue_valid = 1'b0;
            endcase
        end
    end

    // Set is applied after clear so an issuing long op wins over a same-register writeback.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (pop && dec_long && (dec_rd != 5'd0)) begin
            busy_nxt[dec_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= if_pc;
            inst_mem[wr_ptr] <= if_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else if (flush) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (head_valid && dec_serial) begin
                        if (pop) begin
                            state <= WAIT;
                        end else if (!drained) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (serial_done) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Backpressure cycles (issue_valid high, issue_ready low) are not stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (head_valid && !flush && !issue_valid && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_issue_ctrl.sv
// ============================================================================
// Module      : tb_id_issue_ctrl
// Description : Self-checking bench for id_issue_ctrl; acts as the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic [31:0] dec_inst;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rj;
    logic [4:0]  dec_rk;
    logic        dec_long;
    logic        dec_serial;
    logic        issue_valid;
    logic [31:0] issue_pc;
    logic [31:0] issue_inst;
    logic        issue_ready;
    logic        pipe_empty;
    logic        serial_done;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] stall_cnt;

    // Decoder model: fields packed into the word, or overridden by the table.
    logic       ov;
    logic [4:0] t_rd;
    logic [4:0] t_rj;
    logic [4:0] t_rk;
    assign dec_rd     = ov ? t_rd : dec_inst[4:0];
    assign dec_rj     = ov ? t_rj : dec_inst[9:5];
    assign dec_rk     = ov ? t_rk : dec_inst[14:10];
    assign dec_long   = ov ? 1'b0 : dec_inst[15];
    assign dec_serial = ov ? 1'b0 : dec_inst[16];

    id_issue_ctrl #(.DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
        .dec_inst(dec_inst), .dec_rd(dec_rd), .dec_rj(dec_rj), .dec_rk(dec_rk),
        .dec_long(dec_long), .dec_serial(dec_serial),
        .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_inst(issue_inst),
        .issue_ready(issue_ready), .pipe_empty(pipe_empty), .serial_done(serial_done),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_issued = 0;
    int          exp_stall = 0;
    logic [31:0] pc;
    logic [63:0] q[$];

    typedef struct {
        logic [4:0] rd;
        logic [4:0] rj;
        logic [4:0] rk;
        logic       exp;
    } row_t;
    row_t rows[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] tag, input logic [4:0] rd,
                                       input logic [4:0] rj, input logic [4:0] rk,
                                       input logic lng, input logic ser);
        return {tag, 7'd0, ser, lng, rk, rj, rd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
        q.push_back({pc, inst});
        pc = pc + 32'd4;
        tick();
        if_valid = 1'b0;
    endtask

    // Scoreboard: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && issue_valid && issue_ready) begin
            n_issued++;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_issue: got pc %0h expected no issue", issue_pc);
            end else begin
                logic [63:0] e;
                e = q.pop_front();
                chk("issue_pc", {32'd0, issue_pc}, {32'd0, e[63:32]});
                chk("issue_inst", {32'd0, issue_inst}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rows[0] = '{5'd1,  5'd2, 5'd3,  1'b1};
        rows[1] = '{5'd1,  5'd5, 5'd3,  1'b0};
        rows[2] = '{5'd1,  5'd2, 5'd9,  1'b0};
        rows[3] = '{5'd5,  5'd2, 5'd3,  1'b0};
        rows[4] = '{5'd9,  5'd0, 5'd0,  1'b0};
        rows[5] = '{5'd0,  5'd0, 5'd0,  1'b1};
        rows[6] = '{5'd0,  5'd5, 5'd9,  1'b0};
        rows[7] = '{5'd2,  5'd0, 5'd31, 1'b1};
        rows[8] = '{5'd31, 5'd9, 5'd0,  1'b0};

        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
        issue_ready = 1'b0; pipe_empty = 1'b1; serial_done = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; ov = 1'b0; t_rd = '0; t_rj = '0; t_rk = '0;
        pc = 32'h1c00_0000;
        repeat (2) tick();
        rst = 1'b0;
        #2;
        chk("rst_if_ready", {63'd0, if_ready}, 64'd1);
        chk("rst_issue_valid", {63'd0, issue_valid}, 64'd0);
        chk("rst_dec_inst", {32'd0, dec_inst}, 64'd0);
        chk("rst_issue_pc", {32'd0, issue_pc}, 64'd0);
        chk("rst_issue_inst", {32'd0, issue_inst}, 64'd0);
        chk("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
        tick();

        // Streaming: eight independent adds back-to-back
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if_valid = 1'b1;
            if_inst  = mk(8'(i), 5'(i + 1), 5'd0, 5'd0, 1'b0, 1'b0);
            if_pc    = pc;
            q.push_back({pc, if_inst});
            pc = pc + 32'd4;
            #2;
            if (i > 0) chk("stream_valid", {63'd0, issue_valid}, 64'd1);
            tick();
        end
        if_valid = 1'b0;
        #2;
        chk("stream_last", {63'd0, issue_valid}, 64'd1);
        tick();
        chk("stream_count", 64'(n_issued), 64'd8);
        chk("stream_stall", {32'd0, stall_cnt}, 64'(exp_stall));

        // Hazard table against busy = {r5, r9}
        push(mk(8'h20, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0));
        push(mk(8'h21, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0));
        tick();
        issue_ready = 1'b0;
        push(mk(8'h22, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0));
        ov = 1'b1;
        for (int i = 0; i < 9; i++) begin
            t_rd = rows[i].rd; t_rj = rows[i].rj; t_rk = rows[i].rk;
            #2;
            chk("table_issue", {63'd0, issue_valid}, {63'd0, rows[i].exp});
            tick();
            if (!rows[i].exp) exp_stall++;
            chk("table_stall", {32'd0, stall_cnt}, 64'(exp_stall));
        end
        ov = 1'b0;
        issue_ready = 1'b1;
        #2;
        chk("table_head", {63'd0, issue_valid}, 64'd1);
        tick();

        // RAW on r5 released by writeback
        push(mk(8'h23, 5'd6, 5'd5, 5'd7, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("raw_hold", {63'd0, issue_valid}, 64'd0);
            tick();
            exp_stall++;
        end
        wb_valid = 1'b1; wb_rd = 5'd5;
        #2;
        chk("raw_wb_cycle", {63'd0, issue_valid}, 64'd0);
        tick();
        exp_stall++;
        wb_valid = 1'b0;
        #2;
        chk("raw_release", {63'd0, issue_valid}, 64'd1);
        tick();
        chk("raw_stall", {32'd0, stall_cnt}, 64'(exp_stall));
        wb_valid = 1'b1; wb_rd = 5'd9;
        tick();
        wb_valid = 1'b0;

        // Set/clear collision on r3
        push(mk(8'h24, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0));
        wb_valid = 1'b1; wb_rd = 5'd3;
        #2;
        chk("collide_issue", {63'd0, issue_valid}, 64'd1);
        tick();
        wb_valid = 1'b0;
        push(mk(8'h25, 5'd8, 5'd3, 5'd0, 1'b0, 1'b0));
        #2;
        chk("collide_stall", {63'd0, issue_valid}, 64'd0);
        tick();
        exp_stall++;
        wb_valid = 1'b1; wb_rd = 5'd3;
        #2;
        chk("collide_wb", {63'd0, issue_valid}, 64'd0);
        tick();
        exp_stall++;
        wb_valid = 1'b0;
        #2;
        chk("collide_release", {63'd0, issue_valid}, 64'd1);
        tick();

        // Serialise: csr behind a pending div with a busy pipe
        pipe_empty = 1'b0;
        push(mk(8'h26, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0));
        push(mk(8'h27, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1));
        push(mk(8'h28, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0));
        exp_stall++;
        #2;
        chk("drain_hold", {63'd0, issue_valid}, 64'd0);
        tick();
        exp_stall++;
        wb_valid = 1'b1; wb_rd = 5'd4;
        #2;
        chk("drain_wb", {63'd0, issue_valid}, 64'd0);
        tick();
        exp_stall++;
        wb_valid = 1'b0;
        #2;
        chk("drain_pipe_busy", {63'd0, issue_valid}, 64'd0);
        tick();
        exp_stall++;
        pipe_empty = 1'b1;
        #2;
        chk("serial_issue", {63'd0, issue_valid}, 64'd1);
        tick();
        for (int k = 0; k < 2; k++) begin
            #2;
            chk("wait_hold", {63'd0, issue_valid}, 64'd0);
            tick();
            exp_stall++;
        end
        serial_done = 1'b1;
        #2;
        chk("wait_done_cycle", {63'd0, issue_valid}, 64'd0);
        tick();
        exp_stall++;
        serial_done = 1'b0;
        #2;
        chk("after_serial", {63'd0, issue_valid}, 64'd1);
        tick();
        chk("serial_stall", {32'd0, stall_cnt}, 64'(exp_stall));

        // Full FIFO and backpressure
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_valid = 1'b1;
            if_inst  = mk(8'(8'h30 + i), 5'(11 + i), 5'd0, 5'd0, 1'b0, 1'b0);
            if_pc    = pc;
            #2;
            chk("fill_ready", {63'd0, if_ready}, 64'd1);
            q.push_back({pc, if_inst});
            pc = pc + 32'd4;
            tick();
        end
        if_inst = mk(8'h34, 5'd15, 5'd0, 5'd0, 1'b0, 1'b0);
        if_pc   = pc;
        #2;
        chk("full_ready", {63'd0, if_ready}, 64'd0);
        tick();
        issue_ready = 1'b1;
        #2;
        chk("full_pop_ready", {63'd0, if_ready}, 64'd0);
        chk("full_pop_valid", {63'd0, issue_valid}, 64'd1);
        tick();
        #2;
        chk("ready_back", {63'd0, if_ready}, 64'd1);
        q.push_back({pc, if_inst});
        pc = pc + 32'd4;
        tick();
        if_valid = 1'b0;
        for (int k = 0; k < 12 && q.size() != 0; k++) tick();
        chk("full_drain", 64'(q.size()), 64'd0);

        // Flush while waiting with three buffered entries
        push(mk(8'h40, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1));
        push(mk(8'h41, 5'd16, 5'd0, 5'd0, 1'b0, 1'b0));
        push(mk(8'h42, 5'd17, 5'd0, 5'd0, 1'b0, 1'b0));
        push(mk(8'h43, 5'd18, 5'd0, 5'd0, 1'b0, 1'b0));
        exp_stall += 2;
        flush = 1'b1; if_valid = 1'b1; if_inst = mk(8'h44, 5'd19, 5'd0, 5'd0, 1'b0, 1'b0);
        q.delete();
        #2;
        chk("flush_valid", {63'd0, issue_valid}, 64'd0);
        tick();
        flush = 1'b0; if_valid = 1'b0;
        #2;
        chk("flush_empty", {32'd0, dec_inst}, 64'd0);
        chk("flush_if_ready", {63'd0, if_ready}, 64'd1);
        chk("flush_no_issue", {63'd0, issue_valid}, 64'd0);
        tick();
        push(mk(8'h45, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0));
        #2;
        chk("flush_run", {63'd0, issue_valid}, 64'd1);
        tick();
        chk("flush_stall", {32'd0, stall_cnt}, 64'(exp_stall));

        // Flush leaves the scoreboard intact
        push(mk(8'h46, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0));
        push(mk(8'h47, 5'd13, 5'd7, 5'd0, 1'b0, 1'b0));
        flush = 1'b1;
        q.delete();
        tick();
        flush = 1'b0;
        push(mk(8'h48, 5'd13, 5'd7, 5'd0, 1'b0, 1'b0));
        #2;
        chk("busy_kept", {63'd0, issue_valid}, 64'd0);
        tick();
        exp_stall++;
        wb_valid = 1'b1; wb_rd = 5'd7;
        #2;
        chk("busy_wb", {63'd0, issue_valid}, 64'd0);
        tick();
        exp_stall++;
        wb_valid = 1'b0;
        #2;
        chk("busy_release", {63'd0, issue_valid}, 64'd1);
        tick();

        // Flush masks an otherwise issuable head
        push(mk(8'h49, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0));
        flush = 1'b1;
        q.delete();
        #2;
        chk("flush_force", {63'd0, issue_valid}, 64'd0);
        tick();
        flush = 1'b0;
        #2;
        chk("flush_force_empty", {32'd0, dec_inst}, 64'd0);
        chk("pre_rst_stall", {32'd0, stall_cnt}, 64'(exp_stall));
        tick();

        // Reset mid-operation with a busy register and a stalled head
        push(mk(8'h50, 5'd20, 5'd0, 5'd0, 1'b1, 1'b0));
        tick();
        issue_ready = 1'b0;
        push(mk(8'h51, 5'd21, 5'd20, 5'd0, 1'b0, 1'b0));
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
        exp_stall = 0;
        #2;
        chk("mid_rst_dec_inst", {32'd0, dec_inst}, 64'd0);
        chk("mid_rst_stall", {32'd0, stall_cnt}, 64'(exp_stall));
        chk("mid_rst_if_ready", {63'd0, if_ready}, 64'd1);
        tick();
        issue_ready = 1'b1;
        push(mk(8'h52, 5'd22, 5'd20, 5'd0, 1'b0, 1'b0));
        #2;
        chk("rst_busy_clear", {63'd0, issue_valid}, 64'd1);
        tick();
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
